// File: rtl/ram_arbiter_pkg.sv
// subleq_pkg: shared FSM encoding, port indices and timing default for the RAM arbiter
package subleq_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} arb_state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_HOST = 1'b1;
  localparam int WAIT_CYC_DEF = 1;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester ports, arbiter status and RAM pins of the two-port arbiter
interface ram_arbiter_if;
  logic cpu_req, host_req, cpu_we, host_we, host_lock;
  logic [7:0] cpu_adr, host_adr, cpu_wdat, host_wdat;
  logic cpu_gnt, host_gnt, cpu_ack, host_ack;
  logic [7:0] rdat, ram_adr, ram_wdat, ram_rdat;
  logic ram_ena, ram_ope, ram_ctl;
  modport master (
    output cpu_req, host_req, cpu_we, host_we, host_lock, cpu_adr, host_adr, cpu_wdat, host_wdat, ram_rdat,
    input cpu_gnt, host_gnt, cpu_ack, host_ack, rdat, ram_adr, ram_wdat, ram_ena, ram_ope, ram_ctl
  );
  modport slave (
    input cpu_req, host_req, cpu_we, host_we, host_lock, cpu_adr, host_adr, cpu_wdat, host_wdat, ram_rdat,
    output cpu_gnt, host_gnt, cpu_ack, host_ack, rdat, ram_adr, ram_wdat, ram_ena, ram_ope, ram_ctl
  );
endinterface

// File: rtl/ram_arbiter_arb.sv
// arb_rr2: two-way round-robin pick with host lock override
module arb_rr2
  import subleq_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lock,
  input  logic       last,
  output logic       winner
);
  // lock forces the host; a tie goes to the port not granted last
  always_comb
    winner = lock ? PORT_HOST : (req[0] & req[1]) ? ~last : req[1] ? PORT_HOST : PORT_CPU;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port RAM arbiter with setup/strobe/done access sequencing
module ram_arbiter
  import subleq_pkg::*;
#(
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input logic clk,
  input logic res,
  ram_arbiter_if.slave bus
);
  arb_state_t state, state_nx;
  logic owner, we, ptr, winner, req_any, last_cyc;
  logic [2:0] cnt;
  assign req_any = bus.host_req | (bus.cpu_req & ~bus.host_lock);
  assign last_cyc = cnt == 3'(WAIT_CYC - 1);
  arb_rr2 u_arb (
    .req({bus.host_req, bus.cpu_req}),
    .lock(bus.host_lock),
    .last(~ptr),
    .winner(winner)
  );
  // state register
  always_ff @(posedge clk or posedge res)
    if (res) state <= IDLE;
    else state <= state_nx;
  // next state: fixed sequence, only IDLE looks at requests
  always_comb
    state_nx = state == IDLE   ? (req_any ? SETUP : IDLE) :
               state == SETUP  ? ACCESS :
               state == ACCESS ? (last_cyc ? DONE : ACCESS) : IDLE;
  // grant latch, address/data capture, strobe counter and read capture
  always_ff @(posedge clk or posedge res)
    if (res) begin
      owner <= PORT_CPU;
      we <= 1'b0;
      ptr <= PORT_CPU;
      cnt <= '0;
      bus.ram_adr <= '0;
      bus.ram_wdat <= '0;
      bus.rdat <= '0;
    end else begin
      if (state == IDLE && req_any) begin
        owner <= winner;
        ptr <= ~winner;
        we <= winner == PORT_HOST ? bus.host_we : bus.cpu_we;
        bus.ram_adr <= winner == PORT_HOST ? bus.host_adr : bus.cpu_adr;
        bus.ram_wdat <= winner == PORT_HOST ? bus.host_wdat : bus.cpu_wdat;
      end
      cnt <= state == ACCESS ? cnt + 3'd1 : '0;
      if (state == ACCESS && last_cyc && !we) bus.rdat <= bus.ram_rdat;
    end
  // RAM strobes, grants and acks decoded from state
  always_comb begin
    bus.ram_ena = state != IDLE;
    bus.ram_ope = !(state == ACCESS && !we);
    bus.ram_ctl = !(state == ACCESS && we);
    bus.cpu_gnt = state != IDLE && owner == PORT_CPU;
    bus.host_gnt = state != IDLE && owner == PORT_HOST;
    bus.cpu_ack = state == DONE && owner == PORT_CPU;
    bus.host_ack = state == DONE && owner == PORT_HOST;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized self-checking bench against a behavioural arbiter/RAM model
module tb_ram_arbiter;
  import subleq_pkg::*;
  logic clk = 1'b0;
  logic res = 1'b0;
  int checks = 0;
  int fails = 0;
  ram_arbiter_if b1();
  ram_arbiter_if b3();
  ram_arbiter #(.WAIT_CYC(1)) dut1 (.clk(clk), .res(res), .bus(b1.slave));
  ram_arbiter #(.WAIT_CYC(3)) dut3 (.clk(clk), .res(res), .bus(b3.slave));
  always #5 clk = ~clk;

  bit [7:0] mem1 [256];
  bit [7:0] mem3 [256];
  bit wr1 [256];
  bit wr3 [256];
  logic [7:0] ref1 [256];
  logic [7:0] ref3 [256];
  bit [1:0] m_ptr;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  assign b1.ram_rdat = wr1[b1.ram_adr] ? mem1[b1.ram_adr] : init_val(b1.ram_adr);
  assign b3.ram_rdat = wr3[b3.ram_adr] ? mem3[b3.ram_adr] : init_val(b3.ram_adr);
  always @(posedge clk) if (b1.ram_ena && !b1.ram_ctl) begin mem1[b1.ram_adr] <= b1.ram_wdat; wr1[b1.ram_adr] <= 1'b1; end
  always @(posedge clk) if (b3.ram_ena && !b3.ram_ctl) begin mem3[b3.ram_adr] <= b3.ram_wdat; wr3[b3.ram_adr] <= 1'b1; end

  typedef struct packed {logic gnt, ack, ope, ctl, ena; logic [7:0] rdat, adr;} obs_t;

  function automatic obs_t see(input bit inst, input logic port);
    obs_t o;
    if (!inst) o = {port ? b1.host_gnt : b1.cpu_gnt, port ? b1.host_ack : b1.cpu_ack, b1.ram_ope, b1.ram_ctl, b1.ram_ena, b1.rdat, b1.ram_adr};
    else o = {port ? b3.host_gnt : b3.cpu_gnt, port ? b3.host_ack : b3.cpu_ack, b3.ram_ope, b3.ram_ctl, b3.ram_ena, b3.rdat, b3.ram_adr};
    return o;
  endfunction

  task automatic drive(input bit inst, input logic port, input logic req, input logic we, input logic [7:0] adr, input logic [7:0] wdat);
    if (!inst) begin
      if (port) {b1.host_req, b1.host_we, b1.host_adr, b1.host_wdat} = {req, we, adr, wdat};
      else {b1.cpu_req, b1.cpu_we, b1.cpu_adr, b1.cpu_wdat} = {req, we, adr, wdat};
    end else begin
      if (port) {b3.host_req, b3.host_we, b3.host_adr, b3.host_wdat} = {req, we, adr, wdat};
      else {b3.cpu_req, b3.cpu_we, b3.cpu_adr, b3.cpu_wdat} = {req, we, adr, wdat};
    end
  endtask

  // one isolated access; request dropped as soon as the grant is seen (in SETUP)
  task automatic run(input bit inst, input logic port, input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                     output int gc, output int ac, output int ol, output int cl, output int na, output int en,
                     output logic [7:0] rd, output logic [7:0] ra);
    obs_t o;
    gc = -1; ac = -1; ol = 0; cl = 0; na = 0; en = 0; rd = '0; ra = '0;
    @(posedge clk); #1;
    drive(inst, port, 1'b1, we, adr, wdat);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      o = see(inst, port);
      if (o.gnt && gc < 0) begin gc = c; ra = o.adr; drive(inst, port, 1'b0, we, adr, wdat); end
      if (!o.ope) ol++;
      if (!o.ctl) cl++;
      if (o.ena) en++;
      if (o.ack) begin na++; if (ac < 0) begin ac = c; rd = o.rdat; end end
    end
    drive(inst, port, 1'b0, we, adr, wdat);
    if (gc >= 0) begin
      m_ptr[inst] = ~port;
      if (we) begin if (inst) ref3[adr] = wdat; else ref1[adr] = wdat; end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); res = 1'b1;
    @(negedge clk); res = 1'b0;
    m_ptr = '0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
    b1.host_lock = 1'b0; b3.host_lock = 1'b0;
    for (int i = 0; i < 256; i++) begin ref1[i] = init_val(8'(i)); ref3[i] = init_val(8'(i)); end
    #2 res = 1'b1;
    #1;
    checks++;
    if ({b1.ram_ena, b1.ram_ope, b1.ram_ctl, b1.cpu_gnt, b1.host_gnt, b1.cpu_ack, b1.host_ack} !== 7'b0110000) begin
      fails++; $display("FAIL reset_ctl1 got=%b want=0110000", {b1.ram_ena, b1.ram_ope, b1.ram_ctl, b1.cpu_gnt, b1.host_gnt, b1.cpu_ack, b1.host_ack});
    end
    checks++;
    if ({b1.ram_adr, b1.ram_wdat, b1.rdat} !== 24'h0) begin
      fails++; $display("FAIL reset_data1 got=%h want=000000", {b1.ram_adr, b1.ram_wdat, b1.rdat});
    end
    checks++;
    if ({b3.ram_ena, b3.ram_ope, b3.ram_ctl, b3.cpu_gnt, b3.host_gnt, b3.ram_adr, b3.rdat} !== {5'b01100, 16'h0}) begin
      fails++; $display("FAIL reset_w3 got=%h want=%h", {b3.ram_ena, b3.ram_ope, b3.ram_ctl, b3.cpu_gnt, b3.host_gnt, b3.ram_adr, b3.rdat}, {5'b01100, 16'h0});
    end
    @(negedge clk); @(negedge clk); res = 1'b0;
    m_ptr = '0;
  endtask

  task automatic test_cpu_read();
    int gc, ac, ol, cl, na, en;
    logic [7:0] rd, ra, exp;
    exp = ref1[8'h10];
    run(0, PORT_CPU, 1'b0, 8'h10, 8'h00, gc, ac, ol, cl, na, en, rd, ra);
    checks++; if (gc !== 1 || ac !== 3) begin fails++; $display("FAIL read_timing gnt=%0d ack=%0d want gnt=1 ack=3", gc, ac); end
    checks++; if (ol !== 1 || cl !== 0) begin fails++; $display("FAIL read_strobe ope_low=%0d ctl_low=%0d want 1/0", ol, cl); end
    checks++; if (rd !== exp) begin fails++; $display("FAIL read_data got=%h want=%h", rd, exp); end
    checks++; if (na !== 1 || en !== 3) begin fails++; $display("FAIL read_ack_ena acks=%0d ena_cycles=%0d want 1/3", na, en); end
    checks++; if (ra !== 8'h10) begin fails++; $display("FAIL read_adr got=%h want=10", ra); end
  endtask

  task automatic test_wait3();
    int gc, ac, ol, cl, na, en;
    logic [7:0] rd, ra, exp;
    run(1, PORT_HOST, 1'b1, 8'h20, 8'h3C, gc, ac, ol, cl, na, en, rd, ra);
    checks++; if (ac !== 5 || na !== 1) begin fails++; $display("FAIL w3_write_ack ack=%0d acks=%0d want 5/1", ac, na); end
    checks++; if (cl !== 3 || ol !== 0 || en !== 5) begin fails++; $display("FAIL w3_write_strobe ctl_low=%0d ope_low=%0d ena=%0d want 3/0/5", cl, ol, en); end
    exp = ref3[8'h20];
    run(1, PORT_CPU, 1'b0, 8'h20, 8'h00, gc, ac, ol, cl, na, en, rd, ra);
    checks++; if (rd !== exp || ol !== 3 || ac !== 5) begin fails++; $display("FAIL w3_readback rd=%h ope_low=%0d ack=%0d want %h/3/5", rd, ol, ac, exp); end
  endtask

  task automatic test_random();
    int gc, ac, ol, cl, na, en, w;
    logic [7:0] rd, ra, exp, adr, wdat;
    bit inst;
    logic port, we;
    for (int i = 0; i < 16; i++) begin
      inst = 1'($urandom_range(0, 1)); port = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      adr = 8'($urandom_range(0, 15)); wdat = 8'($urandom);
      w = inst ? 3 : 1;
      exp = inst ? ref3[adr] : ref1[adr];
      run(inst, port, we, adr, wdat, gc, ac, ol, cl, na, en, rd, ra);
      checks++;
      if (ac !== 2 + w || (we ? cl : ol) !== w || (we ? ol : cl) !== 0 || na !== 1 || ra !== adr) begin
        fails++; $display("FAIL rand_%0d ack=%0d ope_low=%0d ctl_low=%0d acks=%0d adr=%h want ack=%0d strobe=%0d adr=%h", i, ac, ol, cl, na, ra, 2 + w, w, adr);
      end
      if (!we) begin
        checks++; if (rd !== exp) begin fails++; $display("FAIL rand_rd_%0d got=%h want=%h", i, rd, exp); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic pg, g, who, exp;
    int n = 0, ca = 0, ha = 0, bad = 0;
    pulse_reset();
    @(negedge clk);
    drive(0, PORT_CPU, 1'b1, 1'b0, 8'($urandom), 8'h00);
    drive(0, PORT_HOST, 1'b1, 1'b0, 8'($urandom), 8'h00);
    pg = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      g = b1.cpu_gnt | b1.host_gnt;
      if (b1.cpu_ack) ca++;
      if (b1.host_ack) ha++;
      if (g && !pg) begin
        who = b1.host_gnt; exp = m_ptr[0]; m_ptr[0] = ~exp;
        checks++;
        if (who !== exp || (b1.cpu_gnt && b1.host_gnt)) begin fails++; bad++; $display("FAIL rr_grant_%0d got host=%b want host=%b", n, who, exp); end
        n++;
        if (n == 4) begin b1.cpu_req = 1'b0; b1.host_req = 1'b0; end
      end
      pg = g;
    end
    b1.cpu_req = 1'b0; b1.host_req = 1'b0;
    checks++; if (n !== 4 || ca !== 2 || ha !== 2) begin fails++; $display("FAIL rr_count grants=%0d cpu_acks=%0d host_acks=%0d want 4/2/2", n, ca, ha); end
  endtask

  task automatic test_lock();
    logic pg, g, who, exp, lk, cr, hr;
    int n = 0, g3 = -1, cc = -1, bad = 0;
    @(negedge clk);
    lk = 1'b1; cr = 1'b1; hr = 1'b1;
    b1.host_lock = lk;
    drive(0, PORT_CPU, cr, 1'b0, 8'($urandom), 8'h00);
    drive(0, PORT_HOST, hr, 1'b0, 8'($urandom), 8'h00);
    pg = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      g = b1.cpu_gnt | b1.host_gnt;
      if (b1.cpu_gnt && g3 < 0) bad++;
      if (g && !pg) begin
        who = b1.host_gnt;
        exp = lk ? PORT_HOST : (cr && hr) ? m_ptr[0] : hr;
        m_ptr[0] = ~exp;
        checks++; if (who !== exp) begin fails++; $display("FAIL lock_grant_%0d got host=%b want host=%b", n, who, exp); end
        n++;
        if (n == 3) begin g3 = c; lk = 1'b0; hr = 1'b0; b1.host_lock = lk; b1.host_req = hr; end
        else if (who == PORT_CPU) begin cc = c; cr = 1'b0; b1.cpu_req = cr; end
      end
      pg = g;
    end
    b1.cpu_req = 1'b0; b1.host_req = 1'b0; b1.host_lock = 1'b0;
    checks++; if (bad !== 0) begin fails++; $display("FAIL lock_cpu_gnt cycles=%0d want 0", bad); end
    checks++; if (n !== 4 || cc !== g3 + 4) begin fails++; $display("FAIL lock_release grants=%0d cpu_at=%0d want 4 and %0d", n, cc, g3 + 4); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    int na = 0;
    logic seen = 1'b0, exp;
    @(negedge clk);
    drive(0, PORT_CPU, 1'b1, 1'b1, 8'hF0, 8'($urandom));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b1.cpu_gnt) b1.cpu_req = 1'b0;
      if (!b1.ram_ctl) begin hit = 1; break; end
    end
    b1.cpu_req = 1'b0;
    checks++; if (!hit) begin fails++; $display("FAIL rst_mid_access got=no_write_strobe want=write_strobe"); end
    res = 1'b1;
    #1;
    checks++;
    if ({b1.ram_ctl, b1.ram_ena, b1.cpu_gnt} !== 3'b100) begin fails++; $display("FAIL rst_mid_pins got ctl/ena/gnt=%b want=100", {b1.ram_ctl, b1.ram_ena, b1.cpu_gnt}); end
    @(negedge clk); res = 1'b0; m_ptr = '0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (b1.cpu_ack) na++; end
    checks++; if (na !== 0) begin fails++; $display("FAIL rst_mid_ack got=%0d want=0", na); end
    drive(0, PORT_CPU, 1'b1, 1'b0, 8'h01, 8'h00);
    drive(0, PORT_HOST, 1'b1, 1'b0, 8'h02, 8'h00);
    exp = m_ptr[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (b1.cpu_gnt | b1.host_gnt) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || b1.host_gnt !== exp || b1.cpu_gnt === exp) begin
      fails++; $display("FAIL rst_next_grant got cpu=%b host=%b want host=%b", b1.cpu_gnt, b1.host_gnt, exp);
    end
    m_ptr[0] = ~exp;
    b1.cpu_req = 1'b0; b1.host_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_drop();
    int gc, ac, ol, cl, na, en;
    logic [7:0] rd, ra, exp, adr;
    adr = 8'($urandom_range(16, 31));
    exp = ref1[adr];
    run(0, PORT_CPU, 1'b0, adr, 8'h00, gc, ac, ol, cl, na, en, rd, ra);
    checks++; if (gc !== 1 || na !== 1 || ac !== 3 || rd !== exp) begin
      fails++; $display("FAIL drop_setup gnt=%0d acks=%0d ack=%0d rd=%h want 1/1/3/%h", gc, na, ac, rd, exp);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_wait3();
    test_random();
    test_round_robin();
    test_lock();
    test_reset_mid();
    test_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
